// File: rtl/osc_scan_pkg.sv
// Shared types and elaboration helpers for the ring-oscillator scan sequencer.
package osc_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    SMP  = 2'd3
  } scan_state_e;

  // Width of the counter-reset hold counter: RST_CNT_W = clog2(RST_CYC+1).
  function automatic int rst_cnt_width(input int rst_cyc);
    return $clog2(rst_cyc + 1);
  endfunction

  function automatic bit cfg_ok(input int num_osc, input int sel_w, input int rst_cyc);
    return (num_osc >= 2) && (num_osc <= 32) && ((1 << sel_w) >= num_osc) && (rst_cyc >= 1);
  endfunction

endpackage

// File: rtl/osc_next_pick.sv
// Combinational channel picker: lowest enabled index and next enabled index above cur_i.
module osc_next_pick #(
  parameter int NUM_OSC = 10,
  parameter int SEL_W   = 5
) (
  input  logic [NUM_OSC-1:0] mask_i,
  input  logic [SEL_W-1:0]   cur_i,
  output logic [SEL_W-1:0]   next_o,
  output logic [SEL_W-1:0]   first_o,
  output logic               has_next_o
);

  // Scan downwards so the last hit is the lowest qualifying index.
  always_comb begin
    next_o     = '0;
    first_o    = '0;
    has_next_o = 1'b0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = SEL_W'(i);
        if (i > int'(cur_i)) begin
          next_o     = SEL_W'(i);
          has_next_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/osc_scan_ctrl.sv
// Start/stop controlled readout sequencer for the ring-oscillator aging monitor array.
module osc_scan_ctrl
  import osc_scan_pkg::*;
#(
  parameter int NUM_OSC = 10,
  parameter int SEL_W   = 5,
  parameter int WIN_W   = 24,
  parameter int RST_CYC = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [NUM_OSC-1:0] osc_en_i,
  input  logic [WIN_W-1:0]   win_len_i,
  output logic [SEL_W-1:0]   osc_sel_o,
  output logic               cnt_rstn_o,
  output logic               sample_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sweep_o
);

  localparam int RST_CNT_W = rst_cnt_width(RST_CYC);
  localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CNT_W'(RST_CYC - 1);

  if (!cfg_ok(NUM_OSC, SEL_W, RST_CYC)) begin : g_bad_cfg
    $error("osc_scan_ctrl: invalid NUM_OSC/SEL_W/RST_CYC combination");
  end

  scan_state_e          state_q, state_d;
  logic [NUM_OSC-1:0]   mask_q, mask_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic                 mode_q, mode_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 cnt_rstn_q, cnt_rstn_d;
  logic                 sample_q, sample_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sweep_q, sweep_d;

  logic [NUM_OSC-1:0]   pick_mask;
  logic [SEL_W-1:0]     pick_next, pick_first;
  logic                 pick_has_next;
  logic [WIN_W-1:0]     win_load;
  logic                 stop_eff;

  // In IDLE the live mask selects the first channel; afterwards only the shadow copy counts.
  assign pick_mask = (state_q == IDLE) ? osc_en_i : mask_q;

  osc_next_pick #(
    .NUM_OSC (NUM_OSC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .mask_i     (pick_mask),
    .cur_i      (sel_q),
    .next_o     (pick_next),
    .first_o    (pick_first),
    .has_next_o (pick_has_next)
  );

  // A zero window length still gives one counting cycle.
  assign win_load = (win_q == '0) ? '0 : (win_q - WIN_W'(1));
  assign stop_eff = stop_pend_q | stop_i;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    win_d       = win_q;
    mode_d      = mode_q;
    rst_cnt_d   = rst_cnt_q;
    win_cnt_d   = win_cnt_q;
    sel_d       = sel_q;
    cnt_rstn_d  = cnt_rstn_q;
    busy_d      = busy_q;
    sample_d    = 1'b0;
    done_d      = 1'b0;
    sweep_d     = 1'b0;
    stop_pend_d = stop_pend_q | (stop_i & busy_q);

    case (state_q)
      IDLE: begin
        cnt_rstn_d  = 1'b0;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        if (start_i) begin
          mask_d = osc_en_i;
          win_d  = win_len_i;
          mode_d = mode_i;
          if (|osc_en_i) begin
            state_d   = CLR;
            sel_d     = pick_first;
            busy_d    = 1'b1;
            rst_cnt_d = RST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CLR: begin
        cnt_rstn_d = 1'b0;
        if (rst_cnt_q == '0) begin
          state_d    = RUN;
          cnt_rstn_d = 1'b1;
          win_cnt_d  = win_load;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
        end
      end
      RUN: begin
        cnt_rstn_d = 1'b1;
        if (win_cnt_q == '0) begin
          state_d  = SMP;
          sample_d = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      SMP: begin
        // Leaving a sample: advance, wrap for continuous mode, or finish.
        sweep_d = ~pick_has_next;
        if (!stop_eff && (pick_has_next || mode_q)) begin
          state_d    = CLR;
          sel_d      = pick_has_next ? pick_next : pick_first;
          cnt_rstn_d = 1'b0;
          rst_cnt_d  = RST_LOAD;
        end else begin
          state_d     = IDLE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cnt_rstn_d  = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      win_q       <= '0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      rst_cnt_q   <= '0;
      win_cnt_q   <= '0;
      sel_q       <= '0;
      cnt_rstn_q  <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      win_q       <= win_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      rst_cnt_q   <= rst_cnt_d;
      win_cnt_q   <= win_cnt_d;
      sel_q       <= sel_d;
      cnt_rstn_q  <= cnt_rstn_d;
      sample_q    <= sample_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sweep_q     <= sweep_d;
    end
  end

  assign osc_sel_o  = sel_q;
  assign cnt_rstn_o = cnt_rstn_q;
  assign sample_o   = sample_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sweep_o    = sweep_q;

endmodule
